pi_ctrl_mc: RTL and testbench
=============================

PI_CTRL_MC -- requirements
Module: pi_ctrl_mc

Interface
REQ-001 SHALL have parameter D_WIDTH, default 19, signed data width of targets, measurements, coefficients and outputs.
REQ-002 SHALL have parameter Q_BITS, default 15, fractional bits of all fixed-point quantities.
REQ-003 SHALL have parameter N_CH, default 2 (d/q axes), number of time-multiplexed PI channels, range 1-8.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rstb  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port valid_in  input  1  request; sample accepted when valid_in and ready_out are both high at a rising edge.
REQ-007 SHALL have port ready_out  output  1  block idle and able to accept.
REQ-008 SHALL have port tgt_in  input  N_CH*D_WIDTH  packed signed targets, channel 0 in LSBs.
REQ-009 SHALL have port meas_in  input  N_CH*D_WIDTH  packed signed measurements.
REQ-010 SHALL have port coef_wen  input  1  coefficient write strobe.
REQ-011 SHALL have port coef_ch  input  $clog2(N_CH)+1  target channel of write.
REQ-012 SHALL have port coef_addr  input  2  0=Kp, 1=Ki, 2=int_lim, 3=out_lim.
REQ-013 SHALL have port coef_data  input  D_WIDTH  signed write data.
REQ-014 SHALL have port int_clr  input  1  synchronous clear of all integrators.
REQ-015 SHALL have port out_vec  output  N_CH*D_WIDTH  packed signed controller outputs.
REQ-016 SHALL have port valid_out  output  1  one-cycle pulse, out_vec updated.

Function
REQ-017 SHALL write the addressed coefficient register on any edge with coef_wen=1; writes with coef_ch>=N_CH or while rstb high are dropped.
REQ-018 SHALL copy all coefficient registers into active shadow copies at the accepting edge; writes during a computation affect only the next transaction.
REQ-019 SHALL latch tgt_in and meas_in at the accepting edge; later input changes ignored until next accept.
REQ-020 SHALL implement FSM IDLE -> per channel ERR -> PROP -> INT -> OUT, channel index 0..N_CH-1, then DONE -> IDLE.
REQ-021 SHALL drive ready_out=1 only in IDLE; valid_in outside IDLE ignored.
REQ-022 SHALL in ERR compute err = tgt - meas at D_WIDTH+1 bits, saturated to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
REQ-023 SHALL in PROP compute p = (Kp*err) >>> Q_BITS using one shared signed multiplier, full 2*D_WIDTH product, arithmetic shift (floor).
REQ-024 SHALL in INT compute integ = clamp(integ + ((Ki*err) >>> Q_BITS), -int_lim, +int_lim) (anti-windup), same multiplier.
REQ-025 SHALL in OUT write out_vec channel slice = clamp(p + integ, -out_lim, +out_lim); intermediate sums at D_WIDTH+2 bits, no wrap.
REQ-026 SHALL hold out_vec slices of unprocessed channels at previous values; all N_CH slices are final in DONE.
REQ-027 SHALL assert valid_out only in DONE, exactly one cycle, 4*N_CH+1 edges after the accepting edge (9 for N_CH=2).
REQ-028 SHALL treat negative int_lim or out_lim as 0 (output/integrator forced to 0).
REQ-029 SHALL on int_clr=1 zero all integrators at that edge; if coincident with an INT update, clear wins.
REQ-030 SHALL accept a new valid_in in the IDLE cycle immediately following DONE (back-to-back throughput 4*N_CH+2 cycles).

Reset
REQ-031 SHALL while rstb=1 force FSM to IDLE, ready_out=0, valid_out=0, out_vec=0, integrators=0, Kp=Ki=0, int_lim=out_lim=2^(D_WIDTH-1)-1.
REQ-032 SHALL abort any in-flight computation on rstb assertion without emitting valid_out; ready_out=1 from first edge after rstb deasserts.

Verification (D_WIDTH=19, Q_BITS=15, N_CH=2)
REQ-033 SHALL cover: Kp=4096, Ki=512 both channels, tgt0=16384, meas0=0, ch1 tgt=meas=0 -> valid_out 9 edges after accept, out0=2304, out1=0; repeat -> out0=2560.
REQ-034 SHALL cover: Kp=32767, out_lim=1000, err=16384 -> out0=1000; err=-16384 -> out0=-1000.
REQ-035 SHALL cover: tgt=262143, meas=-262144, Kp=32768 -> err saturates 262143, out0=262143 (out_lim default), no wrap to negative.
REQ-036 SHALL cover: int_lim=300, Ki=512, err=16384 repeated -> integ 256, 300, 300; int_clr pulse -> next out reflects integ 256.
REQ-037 SHALL cover: coef write Kp=0 during busy -> current result uses old Kp, next result uses 0; valid_in during busy ignored.
REQ-038 SHALL cover: rstb pulse mid-computation -> no valid_out, out_vec=0, coefficients default, ready_out=1 one edge after release.

Source files
------------

// File: rtl/pi_ctrl_mc.sv
// pi_ctrl_mc: time-multiplexed multi-channel fixed-point PI controller
// sharing one signed multiplier across all channels and both gain terms.
module pi_ctrl_mc #(
   parameter int D_WIDTH = 19,
   parameter int Q_BITS  = 15,
   parameter int N_CH    = 2
) (
   input  logic                         clk,
   input  logic                         rstb,
   input  logic                         valid_in,
   output logic                         ready_out,
   input  logic [N_CH*D_WIDTH-1:0]      tgt_in,
   input  logic [N_CH*D_WIDTH-1:0]      meas_in,
   input  logic                         coef_wen,
   input  logic [$clog2(N_CH):0]        coef_ch,
   input  logic [1:0]                   coef_addr,
   input  logic signed [D_WIDTH-1:0]    coef_data,
   input  logic                         int_clr,
   output logic [N_CH*D_WIDTH-1:0]      out_vec,
   output logic                         valid_out
);
   localparam int CW = $clog2(N_CH) + 1;
   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PW = 2 * D_WIDTH;
   localparam int SW = PW + 1;
   typedef logic signed [D_WIDTH-1:0] dat_t;
   localparam dat_t MAX_V = dat_t'({1'b0, {(D_WIDTH-1){1'b1}}});
   typedef enum logic [2:0] {IDLE, ERR, PROP, INT, OUT, DONE} state_t;
   state_t state, state_nxt;
   logic [IW-1:0] ch, ch_nxt;
   dat_t kp [N_CH], ki [N_CH], il [N_CH], ol [N_CH];
   dat_t kp_s [N_CH], ki_s [N_CH], il_s [N_CH], ol_s [N_CH];
   dat_t integ [N_CH];
   logic [N_CH*D_WIDTH-1:0] tgt_r, meas_r;
   dat_t err_r;
   logic signed [PW-1:0] p_r;
   dat_t tgt_c, meas_c, err_c, mul_a, int_c, out_c;
   logic signed [D_WIDTH:0] diff;
   logic signed [PW-1:0] prod, prod_sh;
   logic signed [SW-1:0] int_sum, out_sum;
   logic accept;
   // Sums are kept wide enough that clamping sees the exact value; negative limits clamp to 0.
   function automatic dat_t clamp(input logic signed [SW-1:0] v, input dat_t lim);
      logic signed [SW-1:0] hi;
      hi = lim[D_WIDTH-1] ? '0 : SW'(lim);
      return (v > hi) ? dat_t'(hi) : (v < -hi) ? dat_t'(-hi) : dat_t'(v);
   endfunction
   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      case (state)
         IDLE: begin
            state_nxt = valid_in ? ERR : IDLE;
            ch_nxt    = '0;
         end
         ERR:  state_nxt = PROP;
         PROP: state_nxt = INT;
         INT:  state_nxt = OUT;
         OUT: begin
            state_nxt = (ch == IW'(N_CH-1)) ? DONE : ERR;
            ch_nxt    = (ch == IW'(N_CH-1)) ? ch : ch + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      ready_out = (state == IDLE) && !rstb;
      valid_out = (state == DONE);
   end
   assign accept  = valid_in && (state == IDLE);
   assign tgt_c   = dat_t'(tgt_r[ch*D_WIDTH +: D_WIDTH]);
   assign meas_c  = dat_t'(meas_r[ch*D_WIDTH +: D_WIDTH]);
   assign diff    = {tgt_c[D_WIDTH-1], tgt_c} - {meas_c[D_WIDTH-1], meas_c};
   assign err_c   = (diff[D_WIDTH] ^ diff[D_WIDTH-1]) ?
                    {diff[D_WIDTH], {(D_WIDTH-1){~diff[D_WIDTH]}}} : diff[D_WIDTH-1:0];
   assign mul_a   = (state == PROP) ? kp_s[ch] : ki_s[ch];
   assign prod    = PW'(mul_a) * PW'(err_r);
   assign prod_sh = prod >>> Q_BITS;
   assign int_sum = SW'(integ[ch]) + SW'(prod_sh);
   assign int_c   = clamp(int_sum, il_s[ch]);
   assign out_sum = SW'(p_r) + SW'(integ[ch]);
   assign out_c   = clamp(out_sum, ol_s[ch]);
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         state   <= IDLE;
         ch      <= '0;
         out_vec <= '0;
         tgt_r   <= '0;
         meas_r  <= '0;
         err_r   <= '0;
         p_r     <= '0;
         for (int i = 0; i < N_CH; i++) begin
            kp[i] <= '0;    ki[i] <= '0;    il[i] <= MAX_V;   ol[i] <= MAX_V;
            kp_s[i] <= '0;  ki_s[i] <= '0;  il_s[i] <= MAX_V; ol_s[i] <= MAX_V;
            integ[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
         if (coef_wen && coef_ch < CW'(N_CH)) begin
            if (coef_addr == 2'd0) kp[coef_ch[IW-1:0]] <= coef_data;
            if (coef_addr == 2'd1) ki[coef_ch[IW-1:0]] <= coef_data;
            if (coef_addr == 2'd2) il[coef_ch[IW-1:0]] <= coef_data;
            if (coef_addr == 2'd3) ol[coef_ch[IW-1:0]] <= coef_data;
         end
         if (accept) begin
            kp_s   <= kp;
            ki_s   <= ki;
            il_s   <= il;
            ol_s   <= ol;
            tgt_r  <= tgt_in;
            meas_r <= meas_in;
         end
         if (state == ERR) err_r <= err_c;
         if (state == PROP) p_r <= prod_sh;
         if (state == INT) integ[ch] <= int_c;
         if (state == OUT) out_vec[ch*D_WIDTH +: D_WIDTH] <= out_c;
         // Placed last so a clear overrides a same-edge integrator update.
         if (int_clr)
            for (int i = 0; i < N_CH; i++) integ[i] <= '0;
      end
   end
endmodule

// File: tb/tb_pi_ctrl_mc.sv
// tb_pi_ctrl_mc: directed-vector bench for pi_ctrl_mc (D_WIDTH=19, Q_BITS=15, N_CH=2)
// with hand-computed expected outputs.
module tb_pi_ctrl_mc;
   logic clk, rstb, valid_in, ready_out, coef_wen, int_clr, valid_out;
   logic [37:0] tgt_in, meas_in, out_vec;
   logic [1:0] coef_ch, coef_addr;
   logic signed [18:0] coef_data;
   int checks = 0, errors = 0, lat;
   logic seen;
   pi_ctrl_mc #(.D_WIDTH(19), .Q_BITS(15), .N_CH(2)) dut (
      .clk(clk), .rstb(rstb), .valid_in(valid_in), .ready_out(ready_out),
      .tgt_in(tgt_in), .meas_in(meas_in), .coef_wen(coef_wen), .coef_ch(coef_ch),
      .coef_addr(coef_addr), .coef_data(coef_data), .int_clr(int_clr),
      .out_vec(out_vec), .valid_out(valid_out));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   function automatic logic signed [31:0] oslice(input int i);
      logic signed [18:0] s;
      s = out_vec[i*19 +: 19];
      return 32'(s);
   endfunction
   task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, act, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge clk); rstb = 1;
      @(negedge clk); rstb = 0;
   endtask
   task automatic set_coef(input int c, input int a, input int d);
      @(negedge clk);
      coef_wen = 1; coef_ch = 2'(c); coef_addr = 2'(a); coef_data = 19'(d);
      @(negedge clk);
      coef_wen = 0;
   endtask
   task automatic start(input int t0, input int m0, input int t1, input int m1);
      @(negedge clk);
      tgt_in = {19'(t1), 19'(t0)};
      meas_in = {19'(m1), 19'(m0)};
      valid_in = 1;
      @(posedge clk);
      #1 valid_in = 0;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!valid_out && n < 40);
      chk("valid_out_seen", 32'(valid_out), 1);
   endtask
   task automatic run(input string tag, input int t0, input int m0, input int t1, input int m1,
                      input int e0, input int e1);
      int n;
      start(t0, m0, t1, m1);
      wait_done(n);
      chk({tag, "_lat"}, n, 9);
      chk({tag, "_out0"}, oslice(0), e0);
      chk({tag, "_out1"}, oslice(1), e1);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(valid_out), 0);
      chk({tag, "_ready"}, 32'(ready_out), 1);
   endtask
   task automatic watch_quiet(input string tag);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | valid_out;
      end
      chk(tag, 32'(seen), 0);
   endtask
   initial begin
      rstb = 0; valid_in = 0; coef_wen = 0; int_clr = 0;
      tgt_in = '0; meas_in = '0; coef_ch = '0; coef_addr = '0; coef_data = '0;
      #2 rstb = 1;
      @(negedge clk);
      chk("rst_ready", 32'(ready_out), 0);
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_out", 32'(out_vec != 0), 0);
      @(negedge clk); rstb = 0;
      #1 chk("rel_ready", 32'(ready_out), 1);
      for (int c = 0; c < 2; c++) begin
         set_coef(c, 0, 4096);
         set_coef(c, 1, 512);
      end
      run("basic1", 16384, 0, 0, 0, 2304, 0);
      run("basic2", 16384, 0, 0, 0, 2560, 0);
      do_reset();
      for (int c = 0; c < 2; c++) begin
         set_coef(c, 0, 32767);
         set_coef(c, 3, 1000);
      end
      run("olim_a", 16384, 0, -16384, 0, 1000, -1000);
      run("olim_b", -16384, 0, 16384, 0, -1000, 1000);
      set_coef(0, 3, -5);
      run("olim_neg", 16384, 0, 0, 0, 0, 0);
      do_reset();
      set_coef(0, 0, 32768);
      run("errsat", 262143, -262144, 0, 0, 262143, 0);
      do_reset();
      set_coef(0, 1, 512);
      set_coef(0, 2, 300);
      run("ilim1", 16384, 0, 0, 0, 256, 0);
      run("ilim2", 16384, 0, 0, 0, 300, 0);
      run("ilim3", 16384, 0, 0, 0, 300, 0);
      @(negedge clk); int_clr = 1;
      @(negedge clk); int_clr = 0;
      run("iclr", 16384, 0, 0, 0, 256, 0);
      do_reset();
      set_coef(0, 0, 4096);
      start(16384, 0, 0, 0);
      repeat (2) @(negedge clk);
      coef_wen = 1; coef_ch = 0; coef_addr = 0; coef_data = 0;
      valid_in = 1; tgt_in = '0;
      @(negedge clk);
      coef_wen = 0; valid_in = 0;
      wait_done(lat);
      chk("busy_lat", lat, 6);
      chk("busy_out0", oslice(0), 2048);
      watch_quiet("busy_no_restart");
      run("busy_next", 16384, 0, 0, 0, 0, 0);
      do_reset();
      set_coef(0, 0, 4096);
      start(16384, 0, 0, 0);
      repeat (5) @(negedge clk);
      chk("abort_mid_out0", oslice(0), 2048);
      rstb = 1;
      #1;
      chk("abort_out", 32'(out_vec != 0), 0);
      chk("abort_ready", 32'(ready_out), 0);
      @(negedge clk); rstb = 0;
      @(posedge clk);
      #1 chk("abort_rel_ready", 32'(ready_out), 1);
      watch_quiet("abort_no_valid");
      run("abort_dflt", 16384, 0, 16384, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
